// File: rtl/mem_rd_arbiter_pkg.sv
// Shared constants and types for the packet-memory read arbiter.
package mem_rd_arbiter_pkg;

   typedef enum logic {
      PRI_CPU = 1'b0,
      PRI_FWD = 1'b1
   } pri_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_FWD = 1'b1
   } owner_e;

   typedef struct packed {
      logic   vld;
      owner_e owner;
   } rd_tag_t;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Requester and shared-memory read signals for mem_rd_arbiter.
interface mem_rd_arbiter_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 64
);
   logic                  cpu_req;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic                  cpu_gnt;
   logic [DATA_WIDTH-1:0] cpu_data;
   logic                  cpu_data_vld;

   logic                  fwd_req;
   logic [ADDR_WIDTH-1:0] fwd_addr;
   logic                  fwd_gnt;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic                  fwd_data_vld;

   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_data_vld;

   modport master (
      input  cpu_req, cpu_addr, fwd_req, fwd_addr, mem_data, mem_data_vld,
      output cpu_gnt, cpu_data, cpu_data_vld,
      output fwd_gnt, fwd_data, fwd_data_vld,
      output mem_rd_en, mem_addr
   );

   modport slave (
      output cpu_req, cpu_addr, fwd_req, fwd_addr, mem_data, mem_data_vld,
      input  cpu_gnt, cpu_data, cpu_data_vld,
      input  fwd_gnt, fwd_data, fwd_data_vld,
      input  mem_rd_en, mem_addr
   );
endinterface

// File: rtl/mem_rd_arbiter_rd_tag_pipe.sv
// Owner tag delay line: a tag entering with mem_rd_en reaches the head
// in the same cycle its read data comes back from memory.
module rd_tag_pipe
   import mem_rd_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  rd_tag_t in_tag,
   output rd_tag_t head_tag
);

   rd_tag_t stage_q [MEM_LAT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < MEM_LAT; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= in_tag;
         for (int unsigned i = 1; i < MEM_LAT; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign head_tag = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one packet-memory read port between the CPU
// adapter and the forwarder, steering returned words back to their owner.
module mem_rd_arbiter
   import mem_rd_arbiter_pkg::*;
#(
   parameter int          ADDR_WIDTH = 9,
   parameter int          DATA_WIDTH = 64,
   parameter int unsigned MEM_LAT    = 2
) (
   input  logic             clk,
   input  logic             rst,
   mem_rd_arbiter_if.master bus
);

   pri_e                  ptr_q, ptr_d;
   logic                  cpu_gnt, fwd_gnt;
   logic                  rd_en_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   owner_e                own_q;
   rd_tag_t               in_tag, head_tag;
   logic [DATA_WIDTH-1:0] cpu_data_q, fwd_data_q;
   logic                  cpu_vld_q, fwd_vld_q;

   // Pointer only matters on contention; it always moves to the loser.
   always_comb begin
      cpu_gnt = 1'b0;
      fwd_gnt = 1'b0;
      ptr_d   = ptr_q;
      if (rst) begin
         if (bus.cpu_req && (!bus.fwd_req || ptr_q == PRI_CPU)) begin
            cpu_gnt = 1'b1;
            ptr_d   = PRI_FWD;
         end else if (bus.fwd_req) begin
            fwd_gnt = 1'b1;
            ptr_d   = PRI_CPU;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= PRI_CPU;
      else      ptr_q <= ptr_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_en_q <= 1'b0;
         addr_q  <= '0;
         own_q   <= OWN_CPU;
      end else begin
         rd_en_q <= cpu_gnt | fwd_gnt;
         if (cpu_gnt) begin
            addr_q <= bus.cpu_addr;
            own_q  <= OWN_CPU;
         end else if (fwd_gnt) begin
            addr_q <= bus.fwd_addr;
            own_q  <= OWN_FWD;
         end
      end
   end

   always_comb begin
      in_tag       = '0;
      in_tag.vld   = rd_en_q;
      in_tag.owner = own_q;
   end

   rd_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_tag   (in_tag),
      .head_tag (head_tag)
   );

   // Returns with no live head tag (stray or pre-reset reads) are dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cpu_data_q <= '0;
         fwd_data_q <= '0;
         cpu_vld_q  <= 1'b0;
         fwd_vld_q  <= 1'b0;
      end else begin
         cpu_vld_q <= 1'b0;
         fwd_vld_q <= 1'b0;
         if (bus.mem_data_vld && head_tag.vld) begin
            if (head_tag.owner == OWN_CPU) begin
               cpu_data_q <= bus.mem_data;
               cpu_vld_q  <= 1'b1;
            end else begin
               fwd_data_q <= bus.mem_data;
               fwd_vld_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.cpu_gnt      = cpu_gnt;
   assign bus.fwd_gnt      = fwd_gnt;
   assign bus.mem_rd_en    = rd_en_q;
   assign bus.mem_addr     = addr_q;
   assign bus.cpu_data     = cpu_data_q;
   assign bus.cpu_data_vld = cpu_vld_q;
   assign bus.fwd_data     = fwd_data_q;
   assign bus.fwd_data_vld = fwd_vld_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed vector table, reset
// sequences and randomized traffic against a cycle-scheduled event model.
module tb_mem_rd_arbiter;
   import mem_rd_arbiter_pkg::*;

   localparam int AW = 9;
   localparam int DW = 64;
   localparam int SL = 16;
   parameter  int MEM_LAT = 2;

   logic clk;
   logic rst;

   mem_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_rd_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LAT    (MEM_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;

   // Reference model: expected events scheduled by absolute cycle number.
   bit            m_ptr_fwd;
   bit            e_en   [SL];
   logic [AW-1:0] e_addr [SL];
   bit            e_cv   [SL];
   bit            e_fv   [SL];
   logic [DW-1:0] e_word [SL];
   logic [DW-1:0] e_cdata, e_fdata;

   // Memory model: returns a word MEM_LAT cycles after each observed read.
   bit            mv [SL];
   logic [DW-1:0] md [SL];

   typedef struct {
      bit            cr;
      logic [AW-1:0] ca;
      bit            fr;
      logic [AW-1:0] fa;
      bit            stray;
      int            g;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [DW-1:0] memword(input logic [AW-1:0] a);
      return 64'h0123_4567_89AB_CDEF ^ ({55'd0, a} * 64'h9E37_79B9_7F4A_7C15);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
   endtask

   task automatic add(input bit cr, input logic [AW-1:0] ca, input bit fr,
                      input logic [AW-1:0] fa, input bit stray, input int g);
      vec_t v;
      v.cr = cr; v.ca = ca; v.fr = fr; v.fa = fa; v.stray = stray; v.g = g;
      tbl.push_back(v);
   endtask

   // tgnt: 0 none, 1 cpu, 2 fwd, -1 take the grant from the model
   task automatic step(input bit r, input bit cr, input logic [AW-1:0] ca,
                       input bit fr, input logic [AW-1:0] fa, input bit stray,
                       input int tgnt);
      int            s, n, d, eg;
      bit            gc, gf;
      logic [AW-1:0] ga;
      @(negedge clk);
      s = cyc % SL;
      if (bus.mem_rd_en === 1'b1) begin
         mv[(cyc + MEM_LAT) % SL] = 1'b1;
         md[(cyc + MEM_LAT) % SL] = memword(bus.mem_addr);
      end
      rst          = r;
      bus.cpu_req  = cr;
      bus.cpu_addr = ca;
      bus.fwd_req  = fr;
      bus.fwd_addr = fa;
      if (mv[s]) begin
         bus.mem_data_vld = 1'b1;
         bus.mem_data     = md[s];
         mv[s]            = 1'b0;
      end else begin
         bus.mem_data_vld = stray;
         bus.mem_data     = {$urandom, $urandom};
      end
      #1;
      if (!r) begin
         m_ptr_fwd = 1'b0;
         for (int i = 0; i < SL; i++) begin
            e_en[i] = 1'b0; e_addr[i] = '0; e_cv[i] = 1'b0; e_fv[i] = 1'b0;
         end
         e_cdata = '0;
         e_fdata = '0;
      end
      gc = r && cr && (!fr || !m_ptr_fwd);
      gf = r && fr && !gc;
      eg = (tgnt >= 0) ? tgnt : (gc ? 1 : (gf ? 2 : 0));
      if (e_cv[s]) e_cdata = e_word[s];
      if (e_fv[s]) e_fdata = e_word[s];
      chk("cpu_gnt",      64'(bus.cpu_gnt),      64'(eg == 1));
      chk("fwd_gnt",      64'(bus.fwd_gnt),      64'(eg == 2));
      chk("mem_rd_en",    64'(bus.mem_rd_en),    64'(e_en[s]));
      if (!r)          chk("mem_addr_rst", 64'(bus.mem_addr), 64'd0);
      else if (e_en[s]) chk("mem_addr",    64'(bus.mem_addr), 64'(e_addr[s]));
      chk("cpu_data_vld", 64'(bus.cpu_data_vld), 64'(e_cv[s]));
      chk("fwd_data_vld", 64'(bus.fwd_data_vld), 64'(e_fv[s]));
      chk("cpu_data",     bus.cpu_data,          e_cdata);
      chk("fwd_data",     bus.fwd_data,          e_fdata);
      e_en[s] = 1'b0; e_cv[s] = 1'b0; e_fv[s] = 1'b0;
      if (gc || gf) begin
         ga = gc ? ca : fa;
         n  = (cyc + 1) % SL;
         d  = (cyc + 2 + MEM_LAT) % SL;
         e_en[n]   = 1'b1;
         e_addr[n] = ga;
         e_cv[d]   = gc;
         e_fv[d]   = gf;
         e_word[d] = memword(ga);
         m_ptr_fwd = gc;
      end
      cyc++;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_addr = '0;
      bus.fwd_req = 1'b0; bus.fwd_addr = '0;
      bus.mem_data_vld = 1'b0; bus.mem_data = '0;

      // Reset state, including grants suppressed while reset is held.
      step(1'b0, 1'b1, 9'h033, 1'b1, 9'h044, 1'b0, 0);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 0);

      for (int i = 0; i < 4; i++) add(1'b0, '0, 1'b1, 9'(9'h100 + i), 1'b0, 2);
      for (int i = 0; i < 7; i++) add(1'b0, '0, 1'b0, '0, 1'b0, 0);
      for (int i = 0; i < 6; i++)
         add(1'b1, 9'(9'h010 + i / 2), 1'b1, 9'(9'h110 + i / 2), 1'b0, (i % 2 == 0) ? 1 : 2);
      for (int i = 0; i < 7; i++) add(1'b0, '0, 1'b0, '0, 1'b0, 0);
      add(1'b1, 9'h0A5, 1'b0, '0, 1'b0, 1);
      for (int i = 0; i < 7; i++) add(1'b0, '0, 1'b0, '0, 1'b0, 0);
      add(1'b1, 9'h0C0, 1'b1, 9'h1C0, 1'b0, 2);
      add(1'b0, '0,     1'b1, 9'h1C1, 1'b0, 2);
      add(1'b1, 9'h0C2, 1'b1, 9'h1C2, 1'b0, 1);
      for (int i = 0; i < 7; i++) add(1'b0, '0, 1'b0, '0, 1'b0, 0);
      add(1'b0, '0, 1'b0, '0, 1'b1, 0);
      add(1'b0, '0, 1'b0, '0, 1'b0, 0);
      add(1'b0, '0, 1'b0, '0, 1'b1, 0);
      add(1'b0, '0, 1'b0, '0, 1'b0, 0);

      foreach (tbl[i]) step(1'b1, tbl[i].cr, tbl[i].ca, tbl[i].fr, tbl[i].fa, tbl[i].stray, tbl[i].g);

      // Reset one cycle after a grant while the memory still returns data.
      step(1'b1, 1'b1, 9'h055, 1'b0, '0, 1'b0, 1);
      step(1'b0, 1'b1, 9'h0AA, 1'b1, 9'h0BB, 1'b0, 0);
      idle(7);
      step(1'b1, 1'b1, 9'h0AA, 1'b1, 9'h0BB, 1'b0, 1);
      idle(7);

      // Randomized traffic with occasional resets and stray returns.
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) != 0),
              ($urandom_range(0, 9) < 6), 9'($urandom),
              ($urandom_range(0, 9) < 6), 9'($urandom),
              ($urandom_range(0, 9) == 0), -1);
      end
      idle(8);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mem_rd_arbiter.md
MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning word address width of the shared packet memory read port.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning width of one memory word (bigword).
REQ-003 SHALL have parameter MEM_LAT, default 2, range 1..4, meaning cycles from mem_rd_en to mem_data_vld.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req  input  1  CPU adapter read request, held until granted.
REQ-007 cpu_addr  input  ADDR_WIDTH  CPU word read address, stable while cpu_req high.
REQ-008 cpu_gnt  output  1  one-cycle pulse: CPU request accepted this cycle.
REQ-009 cpu_data  output  DATA_WIDTH  bigword returned to CPU adapter.
REQ-010 cpu_data_vld  output  1  cpu_data valid this cycle.
REQ-011 fwd_req, fwd_addr, fwd_gnt, fwd_data, fwd_data_vld  same widths/directions/meanings as the cpu_* set, for the forwarder agent.
REQ-012 mem_rd_en  output  1  read strobe to shared memory.
REQ-013 mem_addr  output  ADDR_WIDTH  read word address to shared memory.
REQ-014 mem_data  input  DATA_WIDTH  memory read data.
REQ-015 mem_data_vld  input  1  memory read data valid, exactly MEM_LAT cycles after mem_rd_en.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt is combinational from req and the priority state.
REQ-017 Priority state SHALL be a 1-bit round-robin pointer with states PRI_CPU and PRI_FWD.
REQ-018 Only one requester asserting: it SHALL be granted that cycle regardless of pointer.
REQ-019 Both asserting: requester named by pointer SHALL be granted; the other waits.
REQ-020 After any grant, pointer SHALL move to the non-granted requester; no grant leaves pointer unchanged.
REQ-021 On a grant in cycle t, mem_rd_en SHALL be 1 and mem_addr SHALL equal the granted address in cycle t+1 (registered); mem_rd_en otherwise 0.
REQ-022 Back-to-back grants SHALL be accepted every cycle (throughput one read per cycle).
REQ-023 SHALL track owner of each in-flight read in a MEM_LAT-deep tag pipeline (valid bit + owner bit per stage).
REQ-024 When mem_data_vld is 1, mem_data SHALL be registered into the owner's *_data and its *_data_vld pulsed one cycle later (t+2+MEM_LAT overall); other requester's vld stays 0.
REQ-025 *_data SHALL hold its last value when *_data_vld is 0.
REQ-026 mem_data_vld with head tag invalid SHALL be ignored (no vld to either requester).
REQ-027 Requester deasserting req before grant SHALL not be granted and SHALL not alter the pointer.
REQ-028 Continuous dual requests SHALL alternate grants CPU, FWD, CPU, ... with no starvation beyond one cycle.

Reset
REQ-029 rst low SHALL immediately clear: pointer to PRI_CPU, mem_rd_en 0, mem_addr 0, all tags invalid, cpu_data/fwd_data 0, cpu_data_vld/fwd_data_vld 0.
REQ-030 gnt outputs SHALL be 0 while rst is low.
REQ-031 Reset mid-operation SHALL discard in-flight reads; data returning after rst release for discarded tags SHALL produce no vld.

Structure
REQ-032 Owner encoding (OWN_CPU=0, OWN_FWD=1) and pointer state constants SHALL live in the shared p3 package/header.
REQ-033 Tag pipeline SHALL be one sub-module, rd_tag_pipe, parameterised by MEM_LAT.

Verification
REQ-034 cpu_req=1, cpu_addr=0x0A5 alone -> cpu_gnt same cycle, mem_rd_en/mem_addr=0x0A5 next cycle, cpu_data_vld at t+2+MEM_LAT with memory word, fwd_data_vld never 1.
REQ-035 Both req held 6 cycles, pointer PRI_CPU -> grants C,F,C,F,C,F; returned data steered to matching owner in same order.
REQ-036 fwd_req alone for 4 cycles, addrs 0x100..0x103 -> four consecutive mem_rd_en, four consecutive fwd_data_vld pulses in order.
REQ-037 Grant issued, rst pulsed low one cycle later, memory still returns data -> no *_data_vld, pointer PRI_CPU, outputs zero.
REQ-038 Stray mem_data_vld with no outstanding read -> neither *_data_vld asserted, *_data unchanged.
REQ-039 MEM_LAT=1 and MEM_LAT=4 builds rerun REQ-035 -> correct steering and latency t+2+MEM_LAT.
